// File: rtl/multdiv_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_if
// Description : Start/operand/result bundle for the multdiv block.
//               master : drives the start pulses and operands and observes the
//                        results (testbench or host logic).
//               slave  : the multdiv datapath itself.
//   ctrl_MULT      start pulse for a signed multiply
//   ctrl_DIV       start pulse for a signed divide
//   data_operandA  multiplicand / dividend
//   data_operandB  multiplier / divisor
//   data_result    low half of the product, or the quotient
//   data_exception overflow / divide-by-zero, qualified by data_resultRDY
//   data_resultRDY one-cycle completion pulse
//   busy           operation in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface
`default_nettype wire

// File: rtl/multdiv.sv
`default_nettype none
// ============================================================================
// Module      : multdiv
// Description : Iterative 32-bit signed multiplier (radix-2 Booth) and divider
//               (restoring, on magnitudes). One iteration per cycle, 32
//               iterations, then a one-cycle DONE state: a start in cycle 0
//               gives data_resultRDY in cycle 33.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : multdiv_if.slave (start pulses, operands, result, flags, busy)
// Config      : define MULTDIV_DIV_EN to build the divide datapath. Without it
//               a divide request still runs the full busy/DONE sequence and
//               returns result 0 with the exception flag set.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv #(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      reset,
  multdiv_if.slave  bus
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;

  // Booth working set: {r_acc, r_mq, r_q1} is the 65-bit shift register.
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_q1;
  logic [WIDTH:0]     w_booth_sum;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_mq_nxt;

  // The add/subtract is done one bit wider so that the bit shifted into the
  // accumulator MSB is the true sign even when acc +/- mcand overflows
  // (e.g. multiplicand 0x80000000).
  always_comb begin
    w_booth_sum = {r_acc[WIDTH-1], r_acc};
    case ({r_mq[0], r_q1})
      2'b01:   w_booth_sum = {r_acc[WIDTH-1], r_acc} + {r_mcand[WIDTH-1], r_mcand};
      2'b10:   w_booth_sum = {r_acc[WIDTH-1], r_acc} - {r_mcand[WIDTH-1], r_mcand};
      default: w_booth_sum = {r_acc[WIDTH-1], r_acc};
    endcase
  end

  assign w_acc_nxt = w_booth_sum[WIDTH:1];
  assign w_mq_nxt  = {w_booth_sum[0], r_mq[WIDTH-1:1]};

`ifdef MULTDIV_DIV_EN
  // Restoring divider: r_dq shifts the dividend magnitude out at the top and
  // the quotient bits in at the bottom.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg;
  logic             r_dz;
  logic             r_ovf;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_dq_nxt;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_abs_a   = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign w_abs_b   = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign w_rem_sh  = {r_rem, r_dq[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_dq_nxt  = {r_dq[WIDTH-2:0], w_ge};
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // Multiply wins a simultaneous request.
        if (bus.ctrl_MULT)     w_state_nxt = S_MULT;
        else if (bus.ctrl_DIV) w_state_nxt = S_DIV;
      end
      S_MULT, S_DIV: begin
        if (r_cnt == c_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_mcand  <= '0;
      r_q1     <= 1'b0;
`ifdef MULTDIV_DIV_EN
      r_rem    <= '0;
      r_dq     <= '0;
      r_dvs    <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.ctrl_MULT) begin
            r_acc   <= '0;
            r_mq    <= bus.data_operandB;
            r_mcand <= bus.data_operandA;
            r_q1    <= 1'b0;
          end
`ifdef MULTDIV_DIV_EN
          else if (bus.ctrl_DIV) begin
            r_rem <= '0;
            r_dq  <= w_abs_a;
            r_dvs <= w_abs_b;
            r_neg <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            r_dz  <= (bus.data_operandB == '0);
            r_ovf <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (bus.data_operandB == '1);
          end
`endif
        end
        S_MULT: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= w_acc_nxt;
          r_mq  <= w_mq_nxt;
          r_q1  <= r_mq[0];
          if (r_cnt == c_last) begin
            r_result <= w_mq_nxt;
            // Overflow when the high word is not the sign-extension of the low.
            r_exc    <= (w_acc_nxt != {WIDTH{w_mq_nxt[WIDTH-1]}});
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
`ifdef MULTDIV_DIV_EN
          r_rem <= w_rem_nxt;
          r_dq  <= w_dq_nxt;
          if (r_cnt == c_last) begin
            // The 0x80000000 / -1 magnitude is 0x80000000 with equal signs,
            // so the unnegated quotient already is the required result.
            r_result <= r_dz ? '0 : (r_neg ? -w_dq_nxt : w_dq_nxt);
            r_exc    <= r_dz | r_ovf;
          end
`else
          if (r_cnt == c_last) begin
            r_result <= '0;
            r_exc    <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = (r_state == S_DONE);
  assign bus.busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multdiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv
// Description : Self-checking bench for multdiv. A table of directed multiply
//               and divide vectors is applied one operation at a time; each
//               operation checks ready latency, busy profile, result hold and
//               the final result/flag. Hand-written sequences cover reset
//               state, reset abort and the busy guard / back-to-back start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv;

  typedef struct {
    string       name;
    logic        mult;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_exc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] model_res = '0;
  logic        model_exc = 1'b0;

  multdiv_if #(.WIDTH(32)) bus ();

  multdiv #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int          rdy_n;
    int          rdy_at;
    int          busy_bad;
    logic [31:0] res_got;
    logic [31:0] hold_got;
    logic        exc_got;
    rdy_n    = 0;
    rdy_at   = -1;
    busy_bad = 0;
    res_got  = 'x;
    hold_got = 'x;
    exc_got  = 1'bx;
    @(negedge clk);
    bus.ctrl_MULT     = v.mult;
    bus.ctrl_DIV      = v.div;
    bus.data_operandA = v.a;
    bus.data_operandB = v.b;
    @(posedge clk); #1;
    // Operands change right after the start cycle; must not matter.
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      if (bus.busy !== 1'(cyc <= 33)) busy_bad++;
      if (cyc == 32) hold_got = bus.data_result;
      if (bus.data_resultRDY === 1'b1) begin
        rdy_n++;
        if (rdy_at < 0) begin
          rdy_at  = cyc;
          res_got = bus.data_result;
          exc_got = bus.data_exception;
        end
      end
      @(posedge clk); #1;
    end
    chk({v.name, " rdy_cycle"}, rdy_at, 33);
    chk({v.name, " rdy_count"}, rdy_n, 1);
    chk({v.name, " busy_profile_errs"}, busy_bad, 0);
    chk({v.name, " result_hold"}, hold_got, model_res);
    chk({v.name, " result"}, res_got, v.exp_res);
    chk({v.name, " exception"}, {31'b0, exc_got}, {31'b0, v.exp_exc});
    model_res = v.exp_res;
    model_exc = v.exp_exc;
  endtask

  vec_t vecs[$];

  initial begin
    int abort_errs;
    int abort_rdy;
    int g_rdy_n;
    int g_busy_bad;
    logic [31:0] g_res1;
    logic [31:0] g_res2;
    int g_rdy1;
    int g_rdy2;

    // name, mult, div, a, b, expected result, expected exception
    vecs.push_back('{"mul_7_x_m3",      1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{"mul_ovf_2p32",    1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1});
    vecs.push_back('{"mul_min_x_1",     1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0});
    vecs.push_back('{"collision_6x3",   1'b1, 1'b1, 32'd6,        32'd3,        32'd18,       1'b0});
    vecs.push_back('{"mul_min_x_min",   1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1});
    vecs.push_back('{"mul_m1_x_m1",     1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0});
    vecs.push_back('{"mul_max_x_2",     1'b1, 1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1});
    vecs.push_back('{"mul_zero",        1'b1, 1'b0, 32'd0,        32'd12345,    32'd0,        1'b0});
    vecs.push_back('{"div_by_zero",     1'b0, 1'b1, 32'd5,        32'd0,        32'd0,        1'b1});
`ifdef MULTDIV_DIV_EN
    vecs.push_back('{"div_m7_by_2",     1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{"div_min_by_m1",   1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
    vecs.push_back('{"div_100_by_7",    1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       1'b0});
    vecs.push_back('{"div_7_by_m100",   1'b0, 1'b1, 32'd7,        32'hFFFFFF9C, 32'd0,        1'b0});
    vecs.push_back('{"div_m100_by_m7",  1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0});
    vecs.push_back('{"div_min_by_2",    1'b0, 1'b1, 32'h80000000, 32'd2,        32'hC0000000, 1'b0});
`else
    vecs.push_back('{"div_m7_by_2",     1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'd0,        1'b1});
    vecs.push_back('{"div_min_by_m1",   1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1});
    vecs.push_back('{"div_100_by_7",    1'b0, 1'b1, 32'd100,      32'd7,        32'd0,        1'b1});
`endif

    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    // Reset state; a start pulse under reset must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.ctrl_MULT = 1'b1;
    @(posedge clk); #1;
    bus.ctrl_MULT = 1'b0;
    chk("reset_busy",      {31'b0, bus.busy},           32'd0);
    chk("reset_rdy",       {31'b0, bus.data_resultRDY}, 32'd0);
    chk("reset_result",    bus.data_result,             32'd0);
    chk("reset_exception", {31'b0, bus.data_exception}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset abort: reset sampled at the end of cycle 10 of a multiply.
    abort_errs = 0;
    abort_rdy  = 0;
    @(negedge clk);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'h00001234;
    bus.data_operandB = 32'h00005678;
    @(posedge clk); #1;
    bus.ctrl_MULT = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.data_resultRDY === 1'b1) abort_rdy++;
      if (cyc >= 11) begin
        if (bus.busy !== 1'b0 || bus.data_result !== 32'd0 ||
            bus.data_exception !== 1'b0 || bus.data_resultRDY !== 1'b0)
          abort_errs++;
      end
      if (cyc == 10) rst = 1'b1;
      if (cyc == 11) rst = 1'b0;
      @(posedge clk); #1;
    end
    chk("abort_rdy_pulses", abort_rdy, 0);
    chk("abort_output_errs", abort_errs, 0);
    model_res = '0;
    model_exc = 1'b0;

    // Busy guard: ctrl_DIV in cycle 5 and in the DONE cycle are ignored;
    // a multiply started in cycle 34 is accepted.
    g_rdy_n    = 0;
    g_busy_bad = 0;
    g_rdy1     = -1;
    g_rdy2     = -1;
    g_res1     = 'x;
    g_res2     = 'x;
    @(negedge clk);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    @(posedge clk); #1;
    bus.ctrl_MULT = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (bus.busy !== 1'((cyc <= 33) || (cyc >= 35 && cyc <= 67))) g_busy_bad++;
      if (bus.data_resultRDY === 1'b1) begin
        g_rdy_n++;
        if (g_rdy1 < 0) begin
          g_rdy1 = cyc;
          g_res1 = bus.data_result;
        end else if (g_rdy2 < 0) begin
          g_rdy2 = cyc;
          g_res2 = bus.data_result;
        end
      end
      bus.ctrl_DIV  = (cyc == 5) || (cyc == 33);
      bus.ctrl_MULT = (cyc == 34);
      if (cyc == 5 || cyc == 33) begin
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
      end
      if (cyc == 34) begin
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd5;
      end
      @(posedge clk); #1;
    end
    bus.ctrl_DIV  = 1'b0;
    bus.ctrl_MULT = 1'b0;
    chk("guard_rdy_count", g_rdy_n, 2);
    chk("guard_rdy1_cycle", g_rdy1, 33);
    chk("guard_result1", g_res1, 32'd12);
    chk("guard_rdy2_cycle", g_rdy2, 67);
    chk("guard_result2", g_res2, 32'd25);
    chk("guard_busy_profile_errs", g_busy_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
